// File: rtl/cnn_argmax_tx_if.sv
// Bus between the dense layer / UART transmitter and the argmax result stage.
// Handshake: strt is a one-cycle start pulse qualified by din in the same cycle; trmt is a
// one-cycle request with dout stable until the next trmt; tx_done is a one-cycle completion
// pulse per byte; rdy pulses once after the last byte and bsy covers strt-accept..rdy.
interface cnn_argmax_tx_if #(
    parameter int DW = 18
);
    logic          strt;
    logic [DW-1:0] din [16];
    logic          tx_done;
    logic          trmt;
    logic [7:0]    dout;
    logic [3:0]    class_idx;
    logic          bsy;
    logic          rdy;

    modport master (
        output strt, din, tx_done,
        input  trmt, dout, class_idx, bsy, rdy
    );

    modport slave (
        input  strt, din, tx_done,
        output trmt, dout, class_idx, bsy, rdy
    );
endinterface

// File: rtl/cnn_argmax_tx.sv
// Sequential signed argmax over the captured class scores, followed by a 3-byte result
// frame ({4'hC, idx}, score high byte, score next byte) sent over the trmt/tx_done handshake.
module cnn_argmax_tx #(
    parameter int NUM_CLASSES = 10,
    parameter int DW          = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cnn_argmax_tx_if.slave        bus,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {IDLE, SCAN, SEND, WAIT} state_t;

    localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] score [16];
    logic [DW-1:0] best;
    logic [3:0]    best_idx;
    logic [3:0]    i;
    logic [1:0]    byte_cnt;
    logic          gt;
    logic          done_ok;
    logic          trmt;
    logic [7:0]    dout;
    logic [3:0]    class_idx;
    logic          bsy;
    logic          rdy;

    assign bus.trmt      = trmt;
    assign bus.dout      = dout;
    assign bus.class_idx = class_idx;
    assign bus.bsy       = bsy;
    assign bus.rdy       = rdy;
    assign state_dbg     = state;

    always_comb begin
        gt = $signed(score[i]) > $signed(best);
        // A tx_done arriving while our own trmt is still high belongs to no byte of ours.
        done_ok = bus.tx_done && !trmt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.strt) state_nxt = SCAN;
            SCAN: if (i == LAST) state_nxt = SEND;
            SEND: state_nxt = WAIT;
            WAIT: if (done_ok && byte_cnt == 2'd2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) score[k] <= '0;
            best      <= '0;
            best_idx  <= '0;
            i         <= '0;
            byte_cnt  <= '0;
            trmt      <= 1'b0;
            dout      <= '0;
            class_idx <= '0;
            bsy       <= 1'b0;
            rdy       <= 1'b0;
        end else begin
            trmt <= 1'b0;
            rdy  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.strt) begin
                        for (int k = 0; k < NUM_CLASSES; k++) score[k] <= bus.din[k];
                        best     <= bus.din[0];
                        best_idx <= '0;
                        i        <= 4'd1;
                        bsy      <= 1'b1;
                    end
                end
                SCAN: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (gt) begin
                        best     <= score[i];
                        best_idx <= i;
                    end
                    i <= i + 4'd1;
                    if (i == LAST) class_idx <= gt ? i : best_idx;
                end
                SEND: begin
                    trmt     <= 1'b1;
                    dout     <= {4'hC, class_idx};
                    byte_cnt <= '0;
                end
                WAIT: begin
                    if (done_ok) begin
                        if (byte_cnt != 2'd2) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            trmt     <= 1'b1;
                            dout     <= (byte_cnt == 2'd0) ? best[DW-1 -: 8] : best[DW-9 -: 8];
                        end else begin
                            rdy <= 1'b1;
                            bsy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_argmax_tx.sv
// Directed bench for cnn_argmax_tx: table of score vectors with hand-computed frames,
// plus hand-written reset and mid-frame reset sequences.
module tb_cnn_argmax_tx;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         checks;
    int         errors;
    int         trmt_cnt;

    cnn_argmax_tx_if #(.DW(18)) bus ();

    cnn_argmax_tx #(.NUM_CLASSES(10), .DW(18)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.trmt === 1'b1) trmt_cnt++;

    typedef struct {
        logic [17:0] din [16];
        logic [3:0]  idx;
        logic [7:0]  b [3];
        bit          dup_strt;
        bit          td_coincide;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trmt"}, 32'(bus.trmt), 32'd0);
        check({tag, "_rdy"}, 32'(bus.rdy), 32'd0);
        check({tag, "_bsy"}, 32'(bus.bsy), 32'd0);
        check({tag, "_dout"}, 32'(bus.dout), 32'd0);
        check({tag, "_class_idx"}, 32'(bus.class_idx), 32'd0);
    endtask

    task automatic load_din(input int v);
        for (int k = 0; k < 16; k++) bus.din[k] = vecs[v].din[k];
    endtask

    task automatic wait_trmt(output int cyc);
        cyc = 0;
        while (bus.trmt !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("trmt_timeout", 32'(bus.trmt), 32'd1);
    endtask

    task automatic run_vec(input int v);
        int cyc;
        int start_cnt;
        load_din(v);
        start_cnt = trmt_cnt;
        bus.strt = 1'b1;
        @(negedge clk);
        bus.strt = 1'b0;
        check("bsy_rise", 32'(bus.bsy), 32'd1);
        for (int b = 0; b < 3; b++) begin
            wait_trmt(cyc);
            check(b == 0 ? "first_trmt_latency" : "next_trmt_latency", cyc, b == 0 ? 32'd10 : 32'd0);
            check($sformatf("vec%0d_byte%0d", v, b), 32'(bus.dout), 32'(vecs[v].b[b]));
            if (b == 0) check("class_idx", 32'(bus.class_idx), 32'(vecs[v].idx));
            if (b == 0 && vecs[v].td_coincide) bus.tx_done = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                bus.tx_done = 1'b0;
                check("trmt_width", 32'(bus.trmt), 32'd0);
                if (b == 0 && vecs[v].dup_strt && k == 1) begin
                    for (int j = 0; j < 16; j++) bus.din[j] = 18'h0AAAA;
                    bus.din[4] = 18'h1FFFF;
                    bus.strt   = 1'b1;
                end
                if (k == 2) begin
                    bus.strt = 1'b0;
                    load_din(v);
                end
            end
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            check(b == 2 ? "rdy_pulse" : "rdy_early", 32'(bus.rdy), b == 2 ? 32'd1 : 32'd0);
            if (b == 2) check("bsy_fall", 32'(bus.bsy), 32'd0);
        end
        @(negedge clk);
        check("rdy_width", 32'(bus.rdy), 32'd0);
        check("bsy_idle", 32'(bus.bsy), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("trmt_count", 32'(trmt_cnt - start_cnt), 32'd3);
        check("idx_hold", 32'(bus.class_idx), 32'(vecs[v].idx));
    endtask

    initial begin
        int cyc;
        int start_cnt;
        checks   = 0;
        errors   = 0;
        trmt_cnt = 0;

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 16; k++) vecs[v].din[k] = '0;
            vecs[v].dup_strt    = 1'b0;
            vecs[v].td_coincide = 1'b0;
        end
        // Distinct maximum at index 7.
        for (int k = 0; k < 16; k++) vecs[0].din[k] = 18'h00010;
        vecs[0].din[7] = 18'h00400;
        vecs[0].idx = 4'd7; vecs[0].b[0] = 8'hC7; vecs[0].b[1] = 8'h01; vecs[0].b[2] = 8'h00;
        // Tie between 2 and 5 keeps 2.
        vecs[1].din[2] = 18'h1FFFF; vecs[1].din[5] = 18'h1FFFF;
        vecs[1].idx = 4'd2; vecs[1].b[0] = 8'hC2; vecs[1].b[1] = 8'h7F; vecs[1].b[2] = 8'hFF;
        // All negative: din[i] = -(10-i).
        for (int k = 0; k < 10; k++) vecs[2].din[k] = 18'(-(10 - k));
        vecs[2].idx = 4'd9; vecs[2].b[0] = 8'hC9; vecs[2].b[1] = 8'hFF; vecs[2].b[2] = 8'hFF;
        // Out-of-range classes loaded high, dup strt and coincident tx_done.
        for (int k = 10; k < 16; k++) vecs[3].din[k] = 18'h1FFFF;
        vecs[3].din[0] = 18'h00001;
        vecs[3].idx = 4'd0; vecs[3].b[0] = 8'hC0; vecs[3].b[1] = 8'h00; vecs[3].b[2] = 8'h00;
        vecs[3].dup_strt = 1'b1; vecs[3].td_coincide = 1'b1;
        // Winner at the last index against negative scores.
        for (int k = 0; k < 16; k++) vecs[4].din[k] = 18'h3F000;
        vecs[4].din[9] = 18'h12345;
        vecs[4].idx = 4'd9; vecs[4].b[0] = 8'hC9; vecs[4].b[1] = 8'h48; vecs[4].b[2] = 8'hD1;
        // Winner at index 1, later tie at 8, negative index 0.
        vecs[5].din[0] = 18'(-3); vecs[5].din[1] = 18'd5; vecs[5].din[8] = 18'd5;
        vecs[5].idx = 4'd1; vecs[5].b[0] = 8'hC1; vecs[5].b[1] = 8'h00; vecs[5].b[2] = 8'h01;

        // Reset with random inputs.
        rst_n       = 1'b0;
        bus.strt    = 1'($urandom_range(1, 0));
        bus.tx_done = 1'($urandom_range(1, 0));
        for (int k = 0; k < 16; k++) bus.din[k] = 18'($urandom_range(18'h3FFFF, 0));
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        bus.strt    = 1'b0;
        bus.tx_done = 1'b0;
        rst_n       = 1'b1;
        start_cnt   = trmt_cnt;
        repeat (50) @(negedge clk);
        #1;
        check("reset_no_trmt", 32'(trmt_cnt - start_cnt), 32'd0);
        check_reset_outputs("post_reset");

        for (int v = 0; v < 6; v++) run_vec(v);

        // Mid-frame reset in WAIT after byte 1.
        load_din(0);
        bus.strt = 1'b1;
        @(negedge clk);
        bus.strt = 1'b0;
        wait_trmt(cyc);
        repeat (4) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        check("midreset_byte1", 32'(bus.dout), 32'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        rst_n = 1'b1;
        start_cnt = trmt_cnt;
        repeat (30) @(negedge clk);
        #1;
        check("midreset_no_trmt", 32'(trmt_cnt - start_cnt), 32'd0);
        check("midreset_bsy", 32'(bus.bsy), 32'd0);
        @(negedge clk);
        run_vec(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
